// File: rtl/pc_redirect_ctrl_if.sv
// Execute-to-fetch redirect bus: branch/jump requests in, fetch PC and flush control out.
// The master side is the pipeline (drives requests); the slave side is the PC controller.
interface pc_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             stall;
    logic             br_en;
    logic             br_ne;
    logic             jmp;
    logic             jr;
    logic             z;
    logic [31:0]      rd1;
    logic [31:0]      ex_pc;
    logic [15:0]      offset;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             flush;
    logic             redirect;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, br_en, br_ne, jmp, jr, z, rd1, ex_pc, offset,
        input  pc, pc_plus4, flush, redirect, taken_cnt
    );

    modport slave (
        input  stall, br_en, br_ne, jmp, jr, z, rd1, ex_pc, offset,
        output pc, pc_plus4, flush, redirect, taken_cnt
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC owner: resolves branches/jumps from execute, redirects the PC and
// holds a multi-cycle flush of the younger IF/ID stages after each taken redirect.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    pc_redirect_ctrl_if.slave  bus
);
    typedef enum logic {RUN, FLUSH} state_e;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req;
    logic             accept;
    logic [31:0]      pc_inc;
    logic [31:0]      br_target;
    logic [31:0]      target;

    assign pc_inc    = pc_q + 32'd4;
    assign req       = bus.jr | bus.jmp | (bus.br_en & (bus.z ^ bus.br_ne));
    // Requests seen while flushing come from squashed instructions and are dropped.
    assign accept    = (state_q == RUN) & req & ~rst;
    assign br_target = bus.ex_pc + 32'd4 + {{14{bus.offset[15]}}, bus.offset, 2'b00};
    assign target    = bus.jr ? {bus.rd1[31:2], 2'b00} : br_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            fcnt_q  <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fcnt_d  = fcnt_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                // A redirect wins over stall so a resolved branch is never lost.
                if (accept) begin
                    pc_d    = target;
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_INIT;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (!bus.stall) begin
                    pc_d = pc_inc;
                end
            end
            FLUSH: begin
                if (!bus.stall) begin
                    pc_d = pc_inc;
                    if (fcnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
            end
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_inc;
    assign bus.flush     = (state_q == FLUSH);
    assign bus.redirect  = accept;
    assign bus.taken_cnt = cnt_q;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: one task per scenario, expected values hand-computed.
// A second instance with a 4-bit counter exercises saturation.
module tb_pc_redirect_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl_if #(.CNT_W(16)) bus ();
    pc_redirect_ctrl_if #(.CNT_W(4))  bus4 ();

    pc_redirect_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pc_redirect_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(2), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.br_en = 0; bus.br_ne = 0; bus.jmp = 0; bus.jr = 0; bus.z = 0;
        bus.rd1 = '0; bus.ex_pc = '0; bus.offset = '0;
        bus4.stall = 0; bus4.br_en = 0; bus4.br_ne = 0; bus4.jmp = 0; bus4.jr = 0; bus4.z = 0;
        bus4.rd1 = '0; bus4.ex_pc = '0; bus4.offset = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.jmp = 1'b1;
        tick(); tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
        checks++; if (bus.taken_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bus.taken_cnt); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", bus.redirect); end
        bus.jmp = 1'b0;
        rst = 1'b0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if ({bus.pc, bus.flush, bus.taken_cnt} !== {32'(i * 4), 1'b0, 16'h0}) begin
                errors++;
                $display("FAIL reset_seq%0d: got pc=%h flush=%b cnt=%h want pc=%h flush=0 cnt=0",
                         i, bus.pc, bus.flush, bus.taken_cnt, 32'(i * 4));
            end
        end
        $display("test_reset: pc=%h", bus.pc);
    endtask

    task automatic test_branch_taken();
        bus.br_en = 1; bus.br_ne = 0; bus.z = 1; bus.ex_pc = 32'h100; bus.offset = 16'hFFFE;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %b want 1", bus.redirect); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.pc, bus.flush} !== {32'h0FC, 1'b1}) begin errors++; $display("FAIL beq_target: got pc=%h flush=%b want pc=0fc flush=1", bus.pc, bus.flush); end
        checks++; if (bus.taken_cnt !== 16'd1) begin errors++; $display("FAIL beq_cnt: got %0d want 1", bus.taken_cnt); end
        tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h100, 1'b1}) begin errors++; $display("FAIL beq_flush2: got pc=%h flush=%b want pc=100 flush=1", bus.pc, bus.flush); end
        tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h104, 1'b0}) begin errors++; $display("FAIL beq_flush_end: got pc=%h flush=%b want pc=104 flush=0", bus.pc, bus.flush); end
        $display("test_branch_taken: pc=%h cnt=%0d", bus.pc, bus.taken_cnt);
    endtask

    task automatic test_branch_not_taken();
        bus.br_en = 1; bus.br_ne = 0; bus.z = 0; bus.ex_pc = 32'h100; bus.offset = 16'h0010;
        #1;
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL beq_nt_redirect: got %b want 0", bus.redirect); end
        tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h108, 1'b0}) begin errors++; $display("FAIL beq_nt_pc: got pc=%h flush=%b want pc=108 flush=0", bus.pc, bus.flush); end
        bus.br_ne = 1; bus.z = 0; bus.offset = 16'd3; bus.ex_pc = 32'h20;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL bne_redirect: got %b want 1", bus.redirect); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.pc, bus.flush, bus.taken_cnt} !== {32'h030, 1'b1, 16'd2}) begin errors++; $display("FAIL bne_target: got pc=%h flush=%b cnt=%0d want pc=030 flush=1 cnt=2", bus.pc, bus.flush, bus.taken_cnt); end
        tick(); tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h038, 1'b0}) begin errors++; $display("FAIL bne_after: got pc=%h flush=%b want pc=038 flush=0", bus.pc, bus.flush); end
        $display("test_branch_not_taken: pc=%h cnt=%0d", bus.pc, bus.taken_cnt);
    endtask

    task automatic test_jr_priority();
        bus.jr = 1; bus.rd1 = 32'h0000_1237; bus.jmp = 1; bus.br_en = 1; bus.z = 1;
        bus.ex_pc = 32'h500; bus.offset = 16'h0040;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL jr_redirect: got %b want 1", bus.redirect); end
        tick();
        clear_inputs();
        bus.br_en = 1; bus.z = 1; bus.ex_pc = 32'h100; bus.offset = 16'h0;
        #1;
        checks++; if ({bus.pc, bus.flush} !== {32'h1234, 1'b1}) begin errors++; $display("FAIL jr_target: got pc=%h flush=%b want pc=1234 flush=1", bus.pc, bus.flush); end
        checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL flush_ignore_redirect: got %b want 0", bus.redirect); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.pc, bus.taken_cnt} !== {32'h1238, 16'd3}) begin errors++; $display("FAIL flush_ignore_pc: got pc=%h cnt=%0d want pc=1238 cnt=3", bus.pc, bus.taken_cnt); end
        tick();
        checks++; if ({bus.pc, bus.flush, bus.taken_cnt} !== {32'h123C, 1'b0, 16'd3}) begin errors++; $display("FAIL jr_after: got pc=%h flush=%b cnt=%0d want pc=123c flush=0 cnt=3", bus.pc, bus.flush, bus.taken_cnt); end
        $display("test_jr_priority: pc=%h cnt=%0d", bus.pc, bus.taken_cnt);
    endtask

    task automatic test_stall();
        bus.jmp = 1; bus.ex_pc = 32'h200; bus.offset = 16'h0;
        #1;
        tick();
        clear_inputs();
        bus.stall = 1;
        #1;
        checks++; if ({bus.pc, bus.flush} !== {32'h204, 1'b1}) begin errors++; $display("FAIL stall_entry: got pc=%h flush=%b want pc=204 flush=1", bus.pc, bus.flush); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.pc, bus.flush} !== {32'h204, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold%0d: got pc=%h flush=%b want pc=204 flush=1", i, bus.pc, bus.flush);
            end
        end
        bus.stall = 0;
        tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h208, 1'b1}) begin errors++; $display("FAIL stall_resume: got pc=%h flush=%b want pc=208 flush=1", bus.pc, bus.flush); end
        tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h20C, 1'b0}) begin errors++; $display("FAIL stall_flush_end: got pc=%h flush=%b want pc=20c flush=0", bus.pc, bus.flush); end
        bus.stall = 1;
        tick();
        checks++; if (bus.pc !== 32'h20C) begin errors++; $display("FAIL run_stall_hold: got %h want 20c", bus.pc); end
        bus.jmp = 1; bus.ex_pc = 32'h300; bus.offset = 16'd1;
        #1;
        checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL stall_req_redirect: got %b want 1", bus.redirect); end
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.pc, bus.flush, bus.taken_cnt} !== {32'h308, 1'b1, 16'd5}) begin errors++; $display("FAIL stall_req_target: got pc=%h flush=%b cnt=%0d want pc=308 flush=1 cnt=5", bus.pc, bus.flush, bus.taken_cnt); end
        tick(); tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h310, 1'b0}) begin errors++; $display("FAIL stall_req_after: got pc=%h flush=%b want pc=310 flush=0", bus.pc, bus.flush); end
        $display("test_stall: pc=%h cnt=%0d", bus.pc, bus.taken_cnt);
    endtask

    task automatic test_wrap();
        bus.jr = 1; bus.rd1 = 32'hFFFF_FFF8;
        #1;
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.pc, bus.taken_cnt} !== {32'hFFFF_FFF8, 16'd6}) begin errors++; $display("FAIL wrap_target: got pc=%h cnt=%0d want pc=fffffff8 cnt=6", bus.pc, bus.taken_cnt); end
        tick();
        checks++; if ({bus.pc, bus.pc_plus4} !== {32'hFFFF_FFFC, 32'h0}) begin errors++; $display("FAIL wrap_plus4: got pc=%h pc_plus4=%h want pc=fffffffc pc_plus4=0", bus.pc, bus.pc_plus4); end
        tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h0, 1'b0}) begin errors++; $display("FAIL wrap_zero: got pc=%h flush=%b want pc=0 flush=0", bus.pc, bus.flush); end
        $display("test_wrap: pc=%h", bus.pc);
    endtask

    task automatic test_saturation();
        int pulses = 0;
        checks++; if (bus4.taken_cnt !== 4'h0) begin errors++; $display("FAIL sat_start: got %h want 0", bus4.taken_cnt); end
        bus4.jmp = 1; bus4.ex_pc = 32'h40; bus4.offset = 16'h0;
        #1;
        for (int i = 0; i < 60; i++) begin
            if (bus4.redirect === 1'b1) pulses++;
            tick();
        end
        bus4.jmp = 0;
        checks++; if (pulses !== 20) begin errors++; $display("FAIL sat_pulses: got %0d want 20", pulses); end
        checks++; if (bus4.taken_cnt !== 4'hF) begin errors++; $display("FAIL sat_cnt: got %0d want 15", bus4.taken_cnt); end
        $display("test_saturation: pulses=%0d cnt=%0d", pulses, bus4.taken_cnt);
    endtask

    task automatic test_reset_mid_flush();
        bus.jmp = 1; bus.ex_pc = 32'h80; bus.offset = 16'h0;
        #1;
        tick();
        clear_inputs();
        #1;
        checks++; if ({bus.pc, bus.flush} !== {32'h84, 1'b1}) begin errors++; $display("FAIL rmf_entry: got pc=%h flush=%b want pc=84 flush=1", bus.pc, bus.flush); end
        rst = 1'b1;
        bus.jr = 1; bus.rd1 = 32'h400;
        #1;
        checks++; if ({bus.pc, bus.flush, bus.redirect} !== {32'h0, 1'b0, 1'b0}) begin errors++; $display("FAIL rmf_async: got pc=%h flush=%b redirect=%b want pc=0 flush=0 redirect=0", bus.pc, bus.flush, bus.redirect); end
        checks++; if ({bus.taken_cnt, bus4.taken_cnt} !== {16'h0, 4'h0}) begin errors++; $display("FAIL rmf_cnt: got cnt=%0d cnt4=%0d want 0 0", bus.taken_cnt, bus4.taken_cnt); end
        tick();
        rst = 1'b0;
        clear_inputs();
        tick();
        checks++; if ({bus.pc, bus.flush} !== {32'h4, 1'b0}) begin errors++; $display("FAIL rmf_release: got pc=%h flush=%b want pc=4 flush=0", bus.pc, bus.flush); end
        $display("test_reset_mid_flush: pc=%h", bus.pc);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_branch_taken();
        test_branch_not_taken();
        test_jr_priority();
        test_stall();
        test_wrap();
        test_saturation();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
